// File: rtl/sram_pkg.sv
// Shared types, constants and address mapping for the 32-bit to 2x16-bit SRAM controller.
package sram_pkg;

    localparam int          SRAM_AW   = 18;
    localparam logic [31:0] SRAM_BASE = 32'd1024;
    localparam int          DQ_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    // Byte address -> half-word address; below-base addresses wrap modulo 2^32.
    function automatic logic [SRAM_AW-1:0] map_half(input logic [31:0] address,
                                                     input logic [31:0] base,
                                                     input logic        hi);
        logic [31:0] word;
        word = (address - base) >> 2;
        return {(SRAM_AW - 1)'(word), hi};
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two 16-bit SRAM accesses, low half first.
// ready drops for the whole access so the pipeline freezes around it.
module sram_controller
    import sram_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] SRAM_BASE     = sram_pkg::SRAM_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdEn,
    input  logic               wrEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic [DQ_W-1:0]    sramDqOut,
    input  logic [DQ_W-1:0]    sramDqIn,
    output logic               sramDqOe,
    output logic               sramWeN,
    output logic               sramOeN,
    output logic               sramCeN,
    output logic               sramUbN,
    output logic               sramLbN
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    state_t            state, next_state;
    logic [CW-1:0]     cnt;
    logic              op_wr;
    logic [31:0]       wd;
    logic [DQ_W-1:0]   rd_lo;
    logic              ce_n;
    logic              req;
    logic              last;

    assign req  = rdEn | wrEn;
    assign last = (cnt == CW'(ACCESS_CYCLES - 1));

    // NOTE: non-blocking assignments throughout so every register samples the pre-edge values.
    // NOTE: the reset clears datapath registers too, because readData and sramAddr have defined reset values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_wr    <= 1'b0;
            wd       <= '0;
            rd_lo    <= '0;
            readData <= '0;
            sramAddr <= '0;
            ce_n     <= 1'b1;
        end else begin
            state <= next_state;
            ce_n  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr    <= wrEn;
                        wd       <= writeData;
                        sramAddr <= map_half(address, SRAM_BASE, 1'b0);
                        cnt      <= '0;
                    end
                end
                LOW: begin
                    if (last) begin
                        cnt         <= '0;
                        sramAddr[0] <= 1'b1;
                        if (!op_wr) rd_lo <= sramDqIn;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    // Low half is held aside so readData only changes once the whole word is in.
                    if (last) begin
                        cnt <= '0;
                        if (!op_wr) readData <= {sramDqIn, rd_lo};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        sramDqOut  = '0;
        sramDqOe   = 1'b0;
        sramWeN    = 1'b1;
        sramOeN    = 1'b1;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) next_state = LOW;
            end
            LOW, HIGH: begin
                if (op_wr) begin
                    sramDqOe  = 1'b1;
                    sramWeN   = 1'b0;
                    sramDqOut = (state == LOW) ? wd[15:0] : wd[31:16];
                end else begin
                    sramOeN = 1'b0;
                end
                if (last) next_state = (state == LOW) ? HIGH : DONE;
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign sramCeN = ce_n;
    assign sramUbN = ce_n;
    assign sramLbN = ce_n;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: table of word accesses against a behavioural SRAM,
// plus hand-written sequences for request drop mid-access and reset abort.
module tb_sram_controller;
    import sram_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               rdEn, wrEn;
    logic [31:0]        address, writeData;
    logic [31:0]        readData;
    logic               ready;
    logic [SRAM_AW-1:0] sramAddr;
    logic [DQ_W-1:0]    sramDqOut, sramDqIn;
    logic               sramDqOe, sramWeN, sramOeN, sramCeN, sramUbN, sramLbN;

    int total = 0;
    int bad   = 0;

    sram_controller dut (
        .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready), .sramAddr(sramAddr),
        .sramDqOut(sramDqOut), .sramDqIn(sramDqIn), .sramDqOe(sramDqOe), .sramWeN(sramWeN),
        .sramOeN(sramOeN), .sramCeN(sramCeN), .sramUbN(sramUbN), .sramLbN(sramLbN)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read; a write commits at the edge unless the controller is being reset.
    logic [DQ_W-1:0] mem [2**SRAM_AW] = '{default: '0};
    assign sramDqIn = mem[sramAddr];
    always @(posedge clk) begin
        if (rst && !sramCeN && !sramWeN) mem[sramAddr] <= sramDqOut;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic        chain;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_read;
        int          lo_idx;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs[8];

    // Starts driving immediately; returns during the DONE cycle with the request still asserted.
    task automatic run_access(input vec_t v);
        int low;
        low       = 0;
        rdEn      = v.rd;
        wrEn      = v.wr;
        address   = v.addr;
        writeData = v.wdata;
        #1;
        while (!ready && low < 20) begin
            if (low == 1) begin
                check("lo_addr", 32'(sramAddr), 32'(v.lo_idx));
                check("lo_wen", 32'(sramWeN), 32'(!v.wr));
                check("lo_oen", 32'(sramOeN), 32'(v.wr));
                check("lo_dqoe", 32'(sramDqOe), 32'(v.wr));
                if (v.wr) check("lo_dq", 32'(sramDqOut), 32'(v.wdata[15:0]));
            end
            if (low == 3) begin
                check("hi_addr", 32'(sramAddr), 32'(v.lo_idx + 1));
                if (v.wr) check("hi_dq", 32'(sramDqOut), 32'(v.wdata[31:16]));
            end
            @(negedge clk);
            #1;
            low++;
        end
        check("busy_cycles", 32'(low), 32'd5);
        check("done_ready", 32'(ready), 32'd1);
        check("done_read", readData, v.exp_read);
        check("done_bus", 32'({sramWeN, sramOeN, sramDqOe}), 32'(3'b110));
        check("mem_lo", 32'(mem[v.lo_idx]), 32'(v.exp_lo));
        check("mem_hi", 32'(mem[v.lo_idx + 1]), 32'(v.exp_hi));
    endtask

    initial begin
        int low;
        //            wr    rd    chain addr        wdata          exp_read      lo_idx   lo        hi
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0000, 0,       16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'hDEAD_BEEF, 0,       16'hBEEF, 16'hDEAD};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0408, 32'h1234_5678, 32'hDEAD_BEEF, 4,       16'h5678, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0408, 32'h0000_0000, 32'h1234_5678, 4,       16'h5678, 16'h1234};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_040C, 32'hA5A5_5A5A, 32'h1234_5678, 6,       16'h5A5A, 16'hA5A5};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_03FC, 32'h0BAD_F00D, 32'h1234_5678, 'h3FFFE, 16'hF00D, 16'h0BAD};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0403, 32'h0000_0000, 32'hDEAD_BEEF, 0,       16'hBEEF, 16'hDEAD};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 32'h0BAD_F00D, 'h3FFFE, 16'hF00D, 16'h0BAD};

        rst = 1'b0; rdEn = 1'b0; wrEn = 1'b0; address = '0; writeData = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_bus", 32'({sramWeN, sramOeN, sramDqOe}), 32'(3'b110));
        check("rst_ce", 32'({sramCeN, sramUbN, sramLbN}), 32'(3'b111));
        check("rst_read", readData, 32'h0);
        check("rst_addr", 32'(sramAddr), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("run_ce", 32'({sramCeN, sramUbN, sramLbN}), 32'(3'b000));
        check("idle_ready", 32'(ready), 32'd1);

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i]);
            @(negedge clk);
            if (!vecs[i].chain) begin
                rdEn = 1'b0;
                wrEn = 1'b0;
                #1;
                check("after_ready", 32'(ready), 32'd1);
                check("after_addr_hold", 32'(sramAddr), 32'(vecs[i].lo_idx + 1));
                check("after_read_hold", readData, vecs[i].exp_read);
                @(negedge clk);
            end
        end

        // Request withdrawn after one cycle: the latched access still runs to completion.
        wrEn = 1'b1; address = 32'h0000_0414; writeData = 32'h1111_2222;
        @(negedge clk);
        wrEn = 1'b0; address = '0; writeData = '0;
        low = 1;
        #1;
        while (!ready && low < 20) begin
            @(negedge clk);
            #1;
            low++;
        end
        check("drop_busy_cycles", 32'(low), 32'd5);
        check("drop_mem_lo", 32'(mem[10]), 32'h2222);
        check("drop_mem_hi", 32'(mem[11]), 32'h1111);
        check("drop_read_hold", readData, 32'h0BAD_F00D);
        @(negedge clk);

        // Reset during the HIGH phase of a write aborts before the high half lands.
        wrEn = 1'b1; address = 32'h0000_0410; writeData = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        #1;
        check("abort_in_high_addr", 32'(sramAddr), 32'd9);
        check("abort_in_high_wen", 32'(sramWeN), 32'd0);
        rst = 1'b0;
        wrEn = 1'b0;
        @(negedge clk);
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_bus", 32'({sramWeN, sramOeN, sramDqOe}), 32'(3'b110));
        check("abort_addr", 32'(sramAddr), 32'h0);
        check("abort_read", readData, 32'h0);
        check("abort_mem_hi", 32'(mem[9]), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
